// File: rtl/reflet_uart_tx_arbiter.sv
// reflet_uart_tx_arbiter: round-robin sharing of one UART tx core between NB_REQ byte sources.
// Optional packet lock, enabled by defining REFLET_UART_ARB_PACKET_LOCK_EN.
//
// state     | meaning
// IDLE      | arbitrate among valid requesters once the tx core is free
// START     | one-cycle uart_start and req_ready pulse for the latched byte
// WAIT_BUSY | wait for the core to raise uart_busy, bounded by BUSY_TIMEOUT
// WAIT_DONE | wait for the core to finish shifting the frame
module reflet_uart_tx_arbiter #(
  parameter int NB_REQ       = 2,
  parameter int BUSY_TIMEOUT = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NB_REQ-1:0]     req_valid,
  input  logic [8*NB_REQ-1:0]   req_data,
  input  logic [NB_REQ-1:0]     req_last,
  output logic [NB_REQ-1:0]     req_ready,
  output logic [7:0]            uart_data,
  output logic                  uart_start,
  input  logic                  uart_busy,
  output logic [1:0]            grant_id,
  output logic                  timeout_err
);

  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

  state_t              state_q, state_d;
  logic [7:0]          timer_q;
  logic                found, take, to_fire, lock_active;
  logic [1:0]          winner;
  logic [7:0]          win_data;
  logic [NB_REQ-1:0]   win_onehot;

  // Two passes give the rotating priority: indices above grant_id first, then the wrap.
  always_comb begin
    found  = 1'b0;
    winner = grant_id;
    if (lock_active) begin
      for (int i = 0; i < NB_REQ; i++)
        if (2'(i) == grant_id && req_valid[i]) found = 1'b1;
    end else begin
      for (int i = 0; i < NB_REQ; i++)
        if (!found && req_valid[i] && 2'(i) > grant_id) begin
          found  = 1'b1;
          winner = 2'(i);
        end
      for (int i = 0; i < NB_REQ; i++)
        if (!found && req_valid[i] && 2'(i) <= grant_id) begin
          found  = 1'b1;
          winner = 2'(i);
        end
    end
  end

  always_comb begin
    win_data   = 8'h00;
    win_onehot = '0;
    for (int i = 0; i < NB_REQ; i++)
      if (2'(i) == winner) begin
        win_data      = req_data[8*i +: 8];
        win_onehot[i] = 1'b1;
      end
  end

  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    to_fire = 1'b0;
    case (state_q)
      IDLE:
        if (found && !uart_busy) begin
          take    = 1'b1;
          state_d = START;
        end
      START:     state_d = WAIT_BUSY;
      WAIT_BUSY:
        if (uart_busy) state_d = WAIT_DONE;
        else if (timer_q == 8'(BUSY_TIMEOUT - 1)) begin
          to_fire = 1'b1;
          state_d = IDLE;
        end
      WAIT_DONE:
        if (!uart_busy) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      req_ready   <= '0;
      uart_start  <= 1'b0;
      uart_data   <= 8'h00;
      grant_id    <= 2'(NB_REQ - 1);
      timeout_err <= 1'b0;
      timer_q     <= 8'h00;
    end else begin
      state_q    <= state_d;
      req_ready  <= '0;
      uart_start <= 1'b0;
      if (take) begin
        uart_data  <= win_data;
        grant_id   <= winner;
        uart_start <= 1'b1;
        req_ready  <= win_onehot;
      end
      timer_q <= (state_q == WAIT_BUSY) ? timer_q + 8'd1 : 8'h00;
      if (to_fire) timeout_err <= 1'b1;
    end
  end

`ifdef REFLET_UART_ARB_PACKET_LOCK_EN
  logic locked_q, win_last;

  always_comb begin
    win_last = 1'b1;
    for (int i = 0; i < NB_REQ; i++)
      if (2'(i) == winner) win_last = req_last[i];
  end

  // Lock follows the last accepted byte; a lost busy handshake abandons the packet.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        locked_q <= 1'b0;
    else if (take)    locked_q <= !win_last;
    else if (to_fire) locked_q <= 1'b0;
  end

  assign lock_active = locked_q;
`else
  logic unused_last;
  assign unused_last = ^req_last;
  assign lock_active = 1'b0;
`endif

endmodule

// File: tb/tb_reflet_uart_tx_arbiter.sv
// Scoreboard bench for reflet_uart_tx_arbiter: queue-level round-robin model predicts byte order.
module tb_reflet_uart_tx_arbiter;
  localparam int NB = 2;
  localparam int BT = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [NB-1:0]     req_valid, req_last, req_ready;
  logic [8*NB-1:0]   req_data;
  logic [7:0]        uart_data;
  logic              uart_start, uart_busy, timeout_err;
  logic [1:0]        grant_id;

  always #5 clk = ~clk;

  reflet_uart_tx_arbiter #(.NB_REQ(NB), .BUSY_TIMEOUT(BT)) dut (
    .clk(clk), .reset(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .uart_data(uart_data),
    .uart_start(uart_start), .uart_busy(uart_busy), .grant_id(grant_id),
    .timeout_err(timeout_err));

  int total = 0;
  int bad   = 0;

  logic [8:0] stg   [NB][$];
  logic [8:0] wq    [NB][$];
  logic [8:0] drv_q [NB][$];
  logic [9:0] exp_q [$];
  int m_last   = NB - 1;
  bit m_locked = 1'b0;

  bit dead = 1'b0;
  bit long_busy = 1'b0;
  int bcnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: serve the staged per-requester queues in round-robin order.
  task automatic commit();
    int pick;
    logic [8:0] e;
    for (int i = 0; i < NB; i++) wq[i] = stg[i];
    forever begin
      pick = -1;
      if (m_locked) begin
        if (wq[m_last].size() > 0) pick = m_last;
      end else begin
        for (int k = 1; k <= NB; k++) begin
          int c;
          c = (m_last + k) % NB;
          if (pick < 0 && wq[c].size() > 0) pick = c;
        end
      end
      if (pick < 0) break;
      e = wq[pick].pop_front();
      exp_q.push_back({2'(pick), e[7:0]});
      m_last = pick;
`ifdef REFLET_UART_ARB_PACKET_LOCK_EN
      m_locked = !e[8];
`endif
    end
    for (int i = 0; i < NB; i++) begin
      drv_q[i] = stg[i];
      stg[i].delete();
    end
  endtask

  task automatic gen(input int i, input int n);
    for (int j = 0; j < n; j++)
      stg[i].push_back({(j == n - 1) ? 1'b1 : 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255))});
  endtask

  task automatic drain(input string nm);
    int c;
    int left;
    c = 0;
    while ((exp_q.size() != 0 || uart_busy) && c < 3000) begin
      @(posedge clk);
      c++;
    end
    total++;
    if (c >= 3000) begin
      bad++;
      $display("FAIL drain_%s: %0d bytes still expected after %0d cycles, required 0", nm, exp_q.size(), c);
    end
    repeat (14) @(posedge clk);
    left = 0;
    for (int i = 0; i < NB; i++) left += drv_q[i].size();
    check({"unconsumed_", nm}, 32'(left), 32'd0);
  endtask

  task automatic wait_start(input string nm);
    int c;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!uart_start && c < 200);
    total++;
    if (!uart_start) begin
      bad++;
      $display("FAIL start_%s: uart_start=0 after %0d cycles, required 1", nm, c);
    end
  endtask

  // Requester drivers: present queue heads, retire a byte on its req_ready pulse.
  always @(negedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (!rst && req_ready[i] && drv_q[i].size() > 0) void'(drv_q[i].pop_front());
      req_valid[i]       = drv_q[i].size() > 0;
      req_data[8*i +: 8] = (drv_q[i].size() > 0) ? drv_q[i][0][7:0] : 8'h00;
      req_last[i]        = (drv_q[i].size() > 0) ? drv_q[i][0][8] : 1'b0;
    end
  end

  // Monitor: every uart_start pops one prediction.
  always @(negedge clk) begin
    logic [9:0] e;
    if (!rst) begin
      if (uart_start) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_start: data=%0h grant=%0d, required no start", uart_data, grant_id);
        end else begin
          e = exp_q.pop_front();
          check("uart_data", 32'(uart_data), 32'(e[7:0]));
          check("grant_id", 32'(grant_id), 32'(e[9:8]));
          check("req_ready", 32'(req_ready), 32'(NB'(1) << e[9:8]));
        end
      end else if (req_ready != '0) begin
        total++;
        bad++;
        $display("FAIL stray_ready: req_ready=%0h without uart_start, required 0", req_ready);
      end
    end
  end

  // Tx core model.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      uart_busy <= 1'b0;
      bcnt      <= 0;
    end else if (uart_start && !dead) begin
      uart_busy <= 1'b1;
      bcnt      <= long_busy ? 30 : int'($urandom_range(1, 6));
    end else if (uart_busy) begin
      if (bcnt <= 1) uart_busy <= 1'b0;
      bcnt <= bcnt - 1;
    end
  end

  task automatic check_reset_outputs(input string nm);
    check({nm, "_req_ready"}, 32'(req_ready), 32'd0);
    check({nm, "_uart_start"}, 32'(uart_start), 32'd0);
    check({nm, "_uart_data"}, 32'(uart_data), 32'h00);
    check({nm, "_grant_id"}, 32'(grant_id), 32'(NB - 1));
    check({nm, "_timeout_err"}, 32'(timeout_err), 32'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk) rst = 1'b0;
    repeat (2) @(posedge clk);

    // single byte
    stg[0].push_back({1'b1, 8'h41});
    commit();
    drain("single");

    // contention, alternating pattern
    for (int j = 0; j < 4; j++) begin
      stg[0].push_back({1'b1, 8'hAA});
      stg[1].push_back({1'b1, 8'h55});
    end
    commit();
    drain("contention");

    // randomized rounds
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NB; i++) gen(i, $urandom_range(0, 5));
      commit();
      drain("random");
    end

    // multi-byte packet on requester 0 against requester 1
    stg[0].push_back({1'b0, 8'hA0});
    stg[0].push_back({1'b0, 8'hA1});
    stg[0].push_back({1'b1, 8'hA2});
    stg[1].push_back({1'b1, 8'hB0});
    stg[1].push_back({1'b1, 8'hB1});
    commit();
    drain("packet");

    // busy never rises
    dead = 1'b1;
    stg[1].push_back({1'b1, 8'h5A});
    commit();
    wait_start("timeout");
    n = 0;
    while (!timeout_err && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("timeout_latency", 32'(n), 32'(BT + 1));
    check("timeout_err_set", 32'(timeout_err), 32'd1);
    dead = 1'b0;
    m_locked = 1'b0;
    stg[0].push_back({1'b1, 8'hC3});
    commit();
    drain("after_timeout");
    check("timeout_err_sticky", 32'(timeout_err), 32'd1);

    // reset while the core is shifting a frame
    long_busy = 1'b1;
    stg[1].push_back({1'b1, 8'h77});
    commit();
    wait_start("midframe");
    repeat (3) @(negedge clk);
    check("midframe_busy", 32'(uart_busy), 32'd1);
    #1 rst = 1'b1;
    #1 check_reset_outputs("midframe");
    long_busy = 1'b0;
    m_last    = NB - 1;
    m_locked  = 1'b0;
    exp_q.delete();
    for (int i = 0; i < NB; i++) drv_q[i].delete();
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    gen(0, 3);
    gen(1, 3);
    commit();
    drain("after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
